// File: rtl/dac_sample_scheduler.sv
// Bit-clock divider, one-entry sample buffer and frame-aligned start/stop/underrun sequencing
// for the left-justified DAC transmitter. Optional underrun counter: DAC_SCHED_UNDERRUN_CNT_EN.
module dac_sample_scheduler #(
    parameter int WIDTH    = 24,
    parameter int DIV_HALF = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic [WIDTH-1:0] sample_left,
    input  logic [WIDTH-1:0] sample_right,
    output logic             bclk,
    output logic             tx_enable,
    output logic [WIDTH-1:0] left_data,
    output logic [WIDTH-1:0] right_data,
    output logic             frame_strobe,
    output logic             underrun,
    output logic [15:0]      underrun_count
);

    localparam int DCW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
    localparam int FCW = $clog2(2 * WIDTH);
    localparam logic [DCW-1:0] DIV_LAST   = DCW'(DIV_HALF - 1);
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(2 * WIDTH - 1);
    localparam logic [FCW-1:0] LOAD_SLOT  = FCW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [DCW-1:0]   div_q, div_d;
    logic             bclk_q, bclk_d;
    logic             txen_q, txen_d;
    logic [WIDTH-1:0] left_q, left_d;
    logic [WIDTH-1:0] right_q, right_d;
    logic             pend_full_q, pend_full_d;
    logic [WIDTH-1:0] pend_l_q, pend_l_d;
    logic [WIDTH-1:0] pend_r_q, pend_r_d;
    logic             ready_q, ready_d;
    logic [FCW-1:0]   frame_q, frame_d;
    logic             wrapped_q, wrapped_d;
    logic             strobe_q, strobe_d;
    logic             und_q, und_d;

    logic tick;
    logic rise_ev;
    logic fall_ev;
    logic load;
    logic mute;
    logic accept;

    always_comb begin
        tick    = (div_q == DIV_LAST);
        rise_ev = tick && !bclk_q;
        fall_ev = tick && bclk_q;
        accept  = sample_valid && ready_q;

        state_d     = state_q;
        div_d       = tick ? '0 : div_q + DCW'(1);
        bclk_d      = tick ? !bclk_q : bclk_q;
        txen_d      = txen_q;
        left_d      = left_q;
        right_d     = right_q;
        pend_full_d = pend_full_q;
        pend_l_d    = pend_l_q;
        pend_r_d    = pend_r_q;
        frame_d     = frame_q;
        wrapped_d   = wrapped_q;
        strobe_d    = 1'b0;
        und_d       = 1'b0;
        load        = 1'b0;
        mute        = 1'b0;

        case (state_q)
            S_IDLE: begin
                frame_d   = '0;
                wrapped_d = 1'b0;
                if (rise_ev && run && pend_full_q) begin
                    load    = 1'b1;
                    state_d = S_PRIME;
                end
            end
            S_PRIME: begin
                frame_d   = '0;
                wrapped_d = 1'b0;
                if (rise_ev) begin
                    txen_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // frame_q tracks the transmitter's bit counter; its wrapping fall is the latch
                if (fall_ev) begin
                    if (frame_q == FRAME_LAST) begin
                        frame_d   = '0;
                        wrapped_d = 1'b1;
                        strobe_d  = 1'b1;
                    end else begin
                        frame_d = frame_q + FCW'(1);
                    end
                end
                if (rise_ev) begin
                    if (frame_q == LOAD_SLOT) begin
                        if (pend_full_q) begin
                            load = 1'b1;
                        end else begin
                            mute = 1'b1;
                        end
                    end
                    if (wrapped_q) begin
                        wrapped_d = 1'b0;
                        if (!run) begin
                            txen_d  = 1'b0;
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                txen_d  = 1'b0;
            end
        endcase

        if (load) begin
            left_d      = pend_l_q;
            right_d     = pend_r_q;
            pend_full_d = 1'b0;
        end
        if (mute) begin
            left_d  = '0;
            right_d = '0;
            und_d   = 1'b1;
        end
        // a same-cycle accept wins over the load's clear, so the new sample is kept
        if (accept) begin
            pend_l_d    = sample_left;
            pend_r_d    = sample_right;
            pend_full_d = 1'b1;
        end
        ready_d = !pend_full_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            bclk_q      <= 1'b0;
            txen_q      <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            pend_full_q <= 1'b0;
            pend_l_q    <= '0;
            pend_r_q    <= '0;
            ready_q     <= 1'b1;
            frame_q     <= '0;
            wrapped_q   <= 1'b0;
            strobe_q    <= 1'b0;
            und_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bclk_q      <= bclk_d;
            txen_q      <= txen_d;
            left_q      <= left_d;
            right_q     <= right_d;
            pend_full_q <= pend_full_d;
            pend_l_q    <= pend_l_d;
            pend_r_q    <= pend_r_d;
            ready_q     <= ready_d;
            frame_q     <= frame_d;
            wrapped_q   <= wrapped_d;
            strobe_q    <= strobe_d;
            und_q       <= und_d;
        end
    end

`ifdef DAC_SCHED_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (mute && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underrun_count = ucnt_q;
`else
    assign underrun_count = '0;
`endif

    assign sample_ready = ready_q;
    assign bclk         = bclk_q;
    assign tx_enable    = txen_q;
    assign left_data    = left_q;
    assign right_data   = right_q;
    assign frame_strobe = strobe_q;
    assign underrun     = und_q;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed bench for dac_sample_scheduler (WIDTH=24, DIV_HALF=2) with a behavioural
// left-justified transmitter that reconstructs each serialized frame.
`timescale 1ns/1ps
module tb_dac_sample_scheduler;
    localparam int WIDTH    = 24;
    localparam int DIV_HALF = 2;
    localparam int FRAME    = 2 * WIDTH * 2 * DIV_HALF;
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
    localparam logic [15:0] EXP_UCNT = 16'd1;
`else
    localparam logic [15:0] EXP_UCNT = 16'd0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             run;
    logic             sample_valid;
    logic             sample_ready;
    logic [WIDTH-1:0] sample_left;
    logic [WIDTH-1:0] sample_right;
    logic             bclk;
    logic             tx_enable;
    logic [WIDTH-1:0] left_data;
    logic [WIDTH-1:0] right_data;
    logic             frame_strobe;
    logic             underrun;
    logic [15:0]      underrun_count;

    dac_sample_scheduler #(.WIDTH(WIDTH), .DIV_HALF(DIV_HALF)) u_dut (
        .clk(clk), .rst(rst), .run(run),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sample_left(sample_left), .sample_right(sample_right),
        .bclk(bclk), .tx_enable(tx_enable),
        .left_data(left_data), .right_data(right_data),
        .frame_strobe(frame_strobe), .underrun(underrun),
        .underrun_count(underrun_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rises = 0;
    int falls = 0;
    int hs_total = 0;
    int up_idx = 0;
    int en_cyc = 0;
    int strobe_cyc = 0;
    int hs_at = 0;
    bit hs_armed = 0;
    logic prev_bclk = 1'b0;
    logic [47:0] acc_q[$];

    // Transmitter model: copies inputs while disabled, shifts MSB-first while enabled,
    // re-latches on its 48th fall.
    logic [47:0] sh;
    logic [47:0] acc;
    logic [47:0] last_frame = '0;
    int bc = 0;
    always @(negedge bclk or posedge rst) begin
        if (rst) begin
            bc = 0; sh = '0; acc = '0;
        end else if (!tx_enable) begin
            sh = {left_data, right_data}; bc = 0; acc = '0;
        end else begin
            acc = {acc[46:0], sh[47]};
            sh  = {sh[46:0], 1'b0};
            if (bc == 47) begin
                last_frame = acc; bc = 0; sh = {left_data, right_data};
            end else begin
                bc++;
            end
        end
    end

    function automatic logic [47:0] sample_of(int idx);
        if (idx == 0) return {24'h123456, 24'hABCDEF};
        return {24'h100000 | 24'(idx), 24'h200000 | 24'(idx)};
    endfunction

    task automatic set_valid(input logic v);
        sample_valid = v;
        hs_armed = sample_valid && sample_ready;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (hs_armed) begin
            acc_q.push_back({sample_left, sample_right});
            hs_total++;
            up_idx++;
            {sample_left, sample_right} = sample_of(up_idx);
        end
        if (bclk && !prev_bclk) rises++;
        if (!bclk && prev_bclk) falls++;
        prev_bclk = bclk;
        hs_armed = sample_valid && sample_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; sample_valid = 1'b0; hs_armed = 0;
        sample_left = '0; sample_right = '0;
        repeat (3) tick();
        checks++; if (bclk !== 1'b0) begin errors++; $display("FAIL reset_bclk: got %b expected 0", bclk); end
        checks++; if (tx_enable !== 1'b0) begin errors++; $display("FAIL reset_tx_enable: got %b expected 0", tx_enable); end
        checks++; if ({left_data, right_data} !== 48'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {left_data, right_data}); end
        checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", sample_ready); end
        checks++; if ({frame_strobe, underrun} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {frame_strobe, underrun}); end
        checks++; if (underrun_count !== 16'h0) begin errors++; $display("FAIL reset_ucnt: got %h expected 0", underrun_count); end
    endtask

    task automatic test_divider();
        logic [7:0] pat;
        pat = '0;
        rst = 1'b0;
        prev_bclk = bclk;
        for (int i = 0; i < 8; i++) begin
            tick();
            pat = {pat[6:0], bclk};
        end
        checks++; if (pat !== 8'b01100110) begin errors++; $display("FAIL divider_pattern: got %b expected 01100110", pat); end
        checks++; if (tx_enable !== 1'b0) begin errors++; $display("FAIL divider_idle_enable: got %b expected 0", tx_enable); end
    endtask

    task automatic test_startup();
        int r0, c0;
        bit primed;
        primed = 0;
        up_idx = 0;
        acc_q.delete();
        {sample_left, sample_right} = sample_of(0);
        set_valid(1'b1);
        for (int n = 0; n < 10 && sample_ready; n++) tick();
        checks++; if (acc_q.size() != 1 || sample_ready !== 1'b0) begin errors++; $display("FAIL preload_handshake: got q=%0d ready=%b expected q=1 ready=0", acc_q.size(), sample_ready); end
        repeat (8) tick();
        checks++; if (tx_enable !== 1'b0 || sample_ready !== 1'b0) begin errors++; $display("FAIL hold_without_run: got en=%b ready=%b expected en=0 ready=0", tx_enable, sample_ready); end
        run = 1'b1;
        r0 = rises; c0 = cyc;
        for (int n = 0; n < 40 && !tx_enable; n++) begin
            tick();
            if (!primed && (rises - r0) >= 1) begin
                primed = 1;
                checks++; if (left_data !== 24'h123456 || right_data !== 24'hABCDEF || tx_enable !== 1'b0) begin errors++; $display("FAIL prime_load: got L=%h R=%h en=%b expected L=123456 R=abcdef en=0", left_data, right_data, tx_enable); end
            end
        end
        en_cyc = cyc;
        checks++; if (tx_enable !== 1'b1) begin errors++; $display("FAIL enable_timeout: got %b expected 1", tx_enable); end
        checks++; if (rises - r0 != 2) begin errors++; $display("FAIL enable_rises: got %0d expected 2", rises - r0); end
        checks++; if (cyc - c0 > 4 * DIV_HALF) begin errors++; $display("FAIL enable_latency: got %0d expected <= %0d", cyc - c0, 4 * DIV_HALF); end
        checks++; if ({left_data, right_data} !== 48'h123456ABCDEF) begin errors++; $display("FAIL enable_data: got %h expected 123456abcdef", {left_data, right_data}); end
    endtask

    task automatic test_first_frame();
        int und_seen;
        und_seen = 0;
        for (int n = 0; n < 2 * FRAME && !frame_strobe; n++) begin
            tick();
            if (underrun) und_seen++;
        end
        checks++; if (frame_strobe !== 1'b1) begin errors++; $display("FAIL first_strobe_timeout: got %b expected 1", frame_strobe); end
        checks++; if (cyc - en_cyc != 2 * DIV_HALF * 47 + DIV_HALF) begin errors++; $display("FAIL first_strobe_time: got %0d expected %0d", cyc - en_cyc, 2 * DIV_HALF * 47 + DIV_HALF); end
        checks++; if (last_frame !== 48'h123456ABCDEF) begin errors++; $display("FAIL first_frame_bits: got %h expected 123456abcdef", last_frame); end
        checks++; if ({left_data, right_data} !== {24'h100001, 24'h200001}) begin errors++; $display("FAIL second_sample_loaded: got %h expected 100001200001", {left_data, right_data}); end
        checks++; if (und_seen != 0) begin errors++; $display("FAIL first_frame_underrun: got %0d expected 0", und_seen); end
        if (acc_q.size() > 0) void'(acc_q.pop_front());
        strobe_cyc = cyc; hs_at = hs_total;
    endtask

    task automatic test_continuous();
        int nstrobe, und_seen;
        logic [WIDTH-1:0] prev_l;
        logic [47:0] exp;
        nstrobe = 0; und_seen = 0; prev_l = left_data;
        for (int n = 0; n < 11 * FRAME && nstrobe < 10; n++) begin
            tick();
            if (underrun) und_seen++;
            if (left_data !== prev_l) begin
                checks++; if (cyc - strobe_cyc != 3 * DIV_HALF) begin errors++; $display("FAIL load_slot: got %0d expected %0d clk after latch", cyc - strobe_cyc, 3 * DIV_HALF); end
                prev_l = left_data;
            end
            if (frame_strobe) begin
                exp = (acc_q.size() > 0) ? acc_q.pop_front() : 48'hx;
                checks++; if (last_frame !== exp) begin errors++; $display("FAIL stream_frame: got %h expected %h", last_frame, exp); end
                checks++; if (cyc - strobe_cyc != FRAME || hs_total - hs_at != 1) begin errors++; $display("FAIL frame_period_hs: got %0d clk %0d hs expected %0d clk 1 hs", cyc - strobe_cyc, hs_total - hs_at, FRAME); end
                strobe_cyc = cyc; hs_at = hs_total; nstrobe++;
            end
        end
        checks++; if (nstrobe != 10) begin errors++; $display("FAIL stream_strobes: got %0d expected 10", nstrobe); end
        checks++; if (und_seen != 0) begin errors++; $display("FAIL stream_underrun: got %0d expected 0", und_seen); end
    endtask

    task automatic test_underrun();
        int nstrobe, und_seen;
        logic [47:0] exp;
        for (int n = 0; n < 2 * FRAME && sample_ready; n++) tick();
        set_valid(1'b0);
        for (int n = 0; n < 3 * FRAME && !underrun; n++) begin
            tick();
            if (frame_strobe) begin
                exp = (acc_q.size() > 0) ? acc_q.pop_front() : 48'hx;
                checks++; if (last_frame !== exp) begin errors++; $display("FAIL pre_underrun_frame: got %h expected %h", last_frame, exp); end
            end
        end
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_timeout: got %b expected 1", underrun); end
        checks++; if ({left_data, right_data} !== 48'h0) begin errors++; $display("FAIL mute_data: got %h expected 0", {left_data, right_data}); end
        checks++; if (acc_q.size() != 1) begin errors++; $display("FAIL underrun_slot: got %0d queued expected 1", acc_q.size()); end
        checks++; if (underrun_count !== EXP_UCNT) begin errors++; $display("FAIL underrun_count: got %0d expected %0d", underrun_count, EXP_UCNT); end
        acc_q.push_back(48'h0);
        set_valid(1'b1);
        tick();
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_width: got %b expected 0", underrun); end
        nstrobe = 0; und_seen = 0;
        for (int n = 0; n < 4 * FRAME && nstrobe < 3; n++) begin
            tick();
            if (underrun) und_seen++;
            if (frame_strobe) begin
                exp = (acc_q.size() > 0) ? acc_q.pop_front() : 48'hx;
                checks++; if (last_frame !== exp) begin errors++; $display("FAIL recover_frame: got %h expected %h", last_frame, exp); end
                nstrobe++;
            end
        end
        checks++; if (nstrobe != 3 || und_seen != 0) begin errors++; $display("FAIL recover: got %0d strobes %0d underruns expected 3 0", nstrobe, und_seen); end
        checks++; if (underrun_count !== EXP_UCNT) begin errors++; $display("FAIL underrun_count_hold: got %0d expected %0d", underrun_count, EXP_UCNT); end
    endtask

    task automatic test_stop();
        int f0, dropped, stray;
        logic [47:0] held;
        dropped = 0; stray = 0;
        for (int n = 0; n < 2 * FRAME && !frame_strobe; n++) tick();
        f0 = falls;
        for (int n = 0; n < 20 * DIV_HALF + 10 && (falls - f0) < 10; n++) tick();
        run = 1'b0;
        for (int n = 0; n < 2 * FRAME && !frame_strobe; n++) begin
            tick();
            if (!tx_enable) dropped++;
        end
        checks++; if (frame_strobe !== 1'b1 || falls - f0 != 48) begin errors++; $display("FAIL stop_latch: got strobe=%b falls=%0d expected strobe=1 falls=48", frame_strobe, falls - f0); end
        checks++; if (dropped != 0) begin errors++; $display("FAIL stop_early: got %0d disabled cycles expected 0", dropped); end
        held = {left_data, right_data};
        tick();
        checks++; if (tx_enable !== 1'b1) begin errors++; $display("FAIL stop_hold_enable: got %b expected 1", tx_enable); end
        tick();
        checks++; if (tx_enable !== 1'b0 || bclk !== 1'b1) begin errors++; $display("FAIL stop_disable: got en=%b bclk=%b expected en=0 bclk=1", tx_enable, bclk); end
        for (int n = 0; n < 2 * FRAME; n++) begin
            tick();
            if (frame_strobe || tx_enable || underrun) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL idle_quiet: got %0d active cycles expected 0", stray); end
        checks++; if ({left_data, right_data} !== held) begin errors++; $display("FAIL stop_keeps_data: got %h expected %h", {left_data, right_data}, held); end
    endtask

    task automatic test_reset_midframe();
        int f0;
        run = 1'b1;
        for (int n = 0; n < 40 && !tx_enable; n++) tick();
        f0 = falls;
        for (int n = 0; n < 60 * DIV_HALF + 10 && (falls - f0) < 30; n++) tick();
        repeat (DIV_HALF) tick();
        checks++; if (bclk !== 1'b1 || tx_enable !== 1'b1) begin errors++; $display("FAIL pre_reset_state: got bclk=%b en=%b expected 1 1", bclk, tx_enable); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bclk !== 1'b0 || tx_enable !== 1'b0) begin errors++; $display("FAIL async_reset_ctl: got bclk=%b en=%b expected 0 0", bclk, tx_enable); end
        checks++; if ({left_data, right_data} !== 48'h0 || sample_ready !== 1'b1) begin errors++; $display("FAIL async_reset_data: got %h ready=%b expected 0 ready=1", {left_data, right_data}, sample_ready); end
        checks++; if (underrun_count !== 16'h0 || frame_strobe !== 1'b0) begin errors++; $display("FAIL async_reset_cnt: got %0d strobe=%b expected 0 0", underrun_count, frame_strobe); end
        run = 1'b0;
        set_valid(1'b0);
        hs_armed = 0;
        acc_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        prev_bclk = bclk;
    endtask

    initial begin
        test_reset();
        test_divider();
        test_startup();
        test_first_frame();
        test_continuous();
        test_underrun();
        test_stop();
        test_reset_midframe();
        test_startup();
        test_first_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
